// File: rtl/int_divider.sv
// -----------------------------------------------------------------------------
// int_divider
//
// Purpose:
//   Multicycle integer divider for the RV32M execute stage. Implements DIV,
//   DIVU, REM and REMU using a radix-2 restoring shift-subtract loop. Every
//   operation takes the same number of cycles, including divide-by-zero and
//   signed overflow, so the control unit can treat it as fixed latency.
//
//   Timeline (E0 = edge that accepts start_i):
//     E0            : operands latched, magnitudes and signs captured -> RUN
//     E1 .. EWIDTH  : one quotient bit per edge
//     EWIDTH+1      : FIN, result formed and registered -> IDLE
//   done_o is high for the single IDLE cycle that follows FIN, and a new
//   start_i may be accepted in that same cycle.
//
// Ports:
//   clk_i         in   rising-edge clock
//   rst_ni        in   asynchronous active-low reset
//   start_i       in   request strobe, sampled only while idle
//   op_i[1:0]     in   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i    in   rs1 value
//   divisor_i     in   rs2 value
//   busy_o        out  high while an operation is in flight (registered)
//   done_o        out  one-cycle pulse when result_o becomes valid (registered)
//   result_o      out  quotient or remainder, held until the next done_o
// -----------------------------------------------------------------------------
module int_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   dividend_q;   // original rs1, needed for REM by zero
  logic [WIDTH-1:0]   divisor_q;    // original rs2, needed for special cases
  logic [WIDTH-1:0]   div_mag_q;    // divisor magnitude used by the loop
  logic [WIDTH-1:0]   rem_q;        // partial remainder
  logic [WIDTH-1:0]   quo_q;        // dividend bits shift out, quotient bits shift in
  logic               q_neg_q;      // quotient must be negated at the end
  logic               r_neg_q;      // remainder must be negated at the end
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;

  // ---------------------------------------------------------------------------
  // Operand conditioning at start: op[0]=1 selects the unsigned variants.
  // ---------------------------------------------------------------------------
  logic             op_signed_d;
  logic             a_neg_d;
  logic             b_neg_d;
  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;

  always_comb begin
    op_signed_d = ~op_i[0];
    a_neg_d     = op_signed_d & dividend_i[WIDTH-1];
    b_neg_d     = op_signed_d & divisor_i[WIDTH-1];
    // INT_MIN negates to itself, which is its correct unsigned magnitude.
    a_mag_d     = a_neg_d ? (~dividend_i + 1'b1) : dividend_i;
    b_mag_d     = b_neg_d ? (~divisor_i + 1'b1) : divisor_i;
  end

  // ---------------------------------------------------------------------------
  // One restoring iteration.
  // The partial remainder is always below the divisor magnitude, so after the
  // shift it fits in WIDTH+1 bits; the top bit of the WIDTH+1-bit difference
  // is then exactly the "trial went negative" flag.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   shifted_rem_d;
  logic [WIDTH:0]   trial_d;
  logic             take_d;
  logic [WIDTH-1:0] rem_step_d;
  logic [WIDTH-1:0] quo_step_d;

  always_comb begin
    shifted_rem_d = {rem_q, quo_q[WIDTH-1]};
    trial_d       = shifted_rem_d - {1'b0, div_mag_q};
    take_d        = ~trial_d[WIDTH];
    rem_step_d    = take_d ? trial_d[WIDTH-1:0] : shifted_rem_d[WIDTH-1:0];
    quo_step_d    = {quo_q[WIDTH-2:0], take_d};
  end

  // ---------------------------------------------------------------------------
  // Final result selection. Divide-by-zero and signed overflow take priority
  // over the loop output so the results match the RISC-V M-extension rules
  // regardless of what the loop produced.
  // ---------------------------------------------------------------------------
  logic             is_rem_d;
  logic             div_zero_d;
  logic             overflow_d;
  logic [WIDTH-1:0] quo_final_d;
  logic [WIDTH-1:0] rem_final_d;
  logic [WIDTH-1:0] result_d;

  always_comb begin
    is_rem_d    = op_q[1];
    div_zero_d  = (divisor_q == '0);
    overflow_d  = ~op_q[0] && (dividend_q == INT_MIN) && (divisor_q == ALL_ONES);
    quo_final_d = q_neg_q ? (~quo_q + 1'b1) : quo_q;
    rem_final_d = r_neg_q ? (~rem_q + 1'b1) : rem_q;

    if (div_zero_d) begin
      result_d = is_rem_d ? dividend_q : ALL_ONES;
    end else if (overflow_d) begin
      result_d = is_rem_d ? '0 : INT_MIN;
    end else begin
      result_d = is_rem_d ? rem_final_d : quo_final_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered busy/done/result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      div_mag_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      // done is a single-cycle pulse; only the FIN branch raises it.
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q       <= op_i;
            dividend_q <= dividend_i;
            divisor_q  <= divisor_i;
            div_mag_q  <= b_mag_d;
            quo_q      <= a_mag_d;
            rem_q      <= '0;
            q_neg_q    <= a_neg_d ^ b_neg_d;
            r_neg_q    <= a_neg_d;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end

        RUN: begin
          rem_q <= rem_step_d;
          quo_q <= quo_step_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_q <= FIN;
          end
        end

        FIN: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_int_divider.sv
// -----------------------------------------------------------------------------
// tb_int_divider
//
// Directed testbench for int_divider: latency, unsigned and signed results,
// divide-by-zero, signed overflow, ignored start while busy, back-to-back
// start in the done cycle, and asynchronous reset mid-operation.
// -----------------------------------------------------------------------------
module tb_int_divider;

  localparam int W = 32;
  localparam int LAT = 33;
  localparam int TIMEOUT = 45;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks;
  int passed;
  int both_high;   // cycles where busy and done were seen high together

  int_divider #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .op_i       (op),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    $display("check %-24s observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Drive a request, let the next edge (E0) take it, then drop start.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  // Count cycles after E0 until done is seen; 'already' is the number of
  // cycles the caller has already stepped. Bounded by TIMEOUT.
  task automatic wait_done(input int already, output int cyc);
    cyc = already;
    while (cyc < TIMEOUT) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy && done) both_high++;
      if (done) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp);
    int cyc;
    launch(o, a, b);
    wait_done(0, cyc);
    check({tag, " latency"}, W'(cyc), W'(LAT));
    check({tag, " result"}, result, exp);
  endtask

  initial begin
    int cyc;
    int done_seen;
    checks    = 0;
    passed    = 0;
    both_high = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    op        = '0;
    dividend  = '0;
    divisor   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    check("reset result", result, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic unsigned
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14);
    run_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2);

    // Signs
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_op("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);
    run_op("div -100/-7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14);

    // Divide by zero
    run_op("div x/0", OP_DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    run_op("divu x/0", OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    run_op("rem x/0", OP_REM, 32'h1234_5678, 32'd0, 32'h1234_5678);
    run_op("remu x/0", OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678);

    // Signed overflow and its unsigned counterparts
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("divu ovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("remu ovf", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

    // start while busy is ignored, start in the done cycle is accepted
    launch(OP_DIVU, 32'd100, 32'd7);
    check("busy after start", W'(busy), 32'd1);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    op       = OP_REMU;
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    wait_done(10, cyc);
    check("ignored start latency", W'(cyc), W'(LAT));
    check("ignored start result", result, 32'd14);
    // Still in the done cycle: launch back-to-back.
    launch(OP_DIVU, 32'd81, 32'd9);
    check("b2b busy", W'(busy), 32'd1);
    check("b2b done low", W'(done), 32'd0);
    wait_done(0, cyc);
    check("b2b latency", W'(cyc), W'(LAT));
    check("b2b result", result, 32'd9);

    // Asynchronous reset mid-operation
    launch(OP_DIVU, 32'd1000, 32'd3);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", W'(busy), '0);
    check("async rst done", W'(done), '0);
    check("async rst result", result, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("no done after rst", W'(done_seen), '0);
    run_op("divu 9/3 after rst", OP_DIVU, 32'd9, 32'd3, 32'd3);

    check("busy&done overlap", W'(both_high), '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/int_divider.md
# int_divider

Multicycle 32-bit integer divider for the RV32M execute stage. It implements DIV, DIVU, REM and REMU with a radix-2 restoring shift-subtract algorithm, which is the subtractive counterpart of the combinational 32-bit adder in the ALU datapath. The control unit starts the divider, stalls the pipeline while `busy` is high, and writes `result` back when `done` pulses. Latency is fixed for every operand combination, including divide-by-zero and signed overflow.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported.
- `clk`  input  1: rising-edge clock.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: request strobe. It is sampled only when the block is idle.
- `op`  input  2: operation select, equal to funct3[1:0]. 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU.
- `dividend`  input  WIDTH: rs1 value.
- `divisor`  input  WIDTH: rs2 value.
- `busy`  output  1: high while an operation is in flight.
- `done`  output  1: one-cycle pulse when `result` becomes valid.
- `result`  output  WIDTH: quotient or remainder. It holds its value until the next `done`.

## Operation
- States: IDLE, RUN, FIN.
- IDLE, with `start`=1 at an edge:
  - Latch `op`, `dividend` and `divisor`.
  - For signed ops, take the magnitudes of both operands.
  - Record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Clear the partial remainder and set the iteration counter to 0.
  - Go to RUN.
- RUN, once per cycle:
  - Shift {partial remainder, quotient register} left by 1.
  - Form the trial value `trial = partial_rem - divisor_mag`, 33 bits wide.
  - If `trial` is non-negative, set partial remainder = `trial` and set the quotient LSB to 1; otherwise set the quotient LSB to 0.
  - After WIDTH iterations (counter 0..WIDTH-1), go to FIN.
- FIN: compute `result` and go to IDLE. `done` is high in the first IDLE cycle.
  - DIVU / REMU: raw quotient or remainder.
  - DIV: negate the quotient if its sign is negative. REM: negate the remainder if the dividend was negative.
- Divisor = 0 overrides the arithmetic in FIN:
  - DIV and DIVU return 0xFFFFFFFF.
  - REM and REMU return the original dividend.
- Signed overflow (DIV or REM with dividend 0x80000000 and divisor 0xFFFFFFFF) overrides the arithmetic in FIN:
  - DIV returns 0x80000000.
  - REM returns 0.
- Operand inputs and `op` are ignored after the start edge. `start` while `busy`=1 is ignored and not queued.
- Reset mid-operation aborts immediately: state goes to IDLE and no `done` is produced.

## Timing
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `result` = 0. The internal counter and registers are cleared to 0.
- Edge numbering: E0 is the edge at which `start` is accepted.
  - `busy` is 1 from after E0 until after E(WIDTH+1).
  - Iterations happen at edges E1..E(WIDTH).
  - FIN happens at edge E(WIDTH+1).
- After E(WIDTH+1), which is E33 for WIDTH=32:
  - `done` = 1 for exactly one cycle.
  - `busy` = 0.
  - `result` is valid.
- Latency from `start` to `done` is WIDTH+1 = 33 cycles for every case. Initiation interval is 34 cycles.
- `start` may be high in the `done` cycle. It is accepted as a back-to-back operation with no idle gap.
- `busy` and `done` are registered outputs with no combinational path from any input.
- `busy` and `done` are never high in the same cycle.

## Test plan
- DIVU 100 / 7:
  - `done` must pulse exactly 33 cycles after the `start` edge.
  - `result` = 14.
  - REMU with the same operands gives 2.
- Sign cases, DIV -7 / 2 and REM -7 / 2:
  - DIV gives 0xFFFFFFFD (-3).
  - REM gives 0xFFFFFFFF (-1).
  - DIV 7 / -2 gives 0xFFFFFFFD.
- Divide by zero with dividend 0x12345678:
  - DIV and DIVU give 0xFFFFFFFF.
  - REM and REMU give 0x12345678.
  - Latency is still 33 cycles.
- Overflow, 0x80000000 / 0xFFFFFFFF:
  - DIV gives 0x80000000.
  - REM gives 0.
  - DIVU gives 0 and REMU gives 0x80000000.
- `start` re-asserted with new operands at cycle 10 of an operation:
  - It must be ignored and the first result must be unchanged.
  - `start` asserted in the `done` cycle must launch a second operation that completes 33 cycles later.
- `rst_n` pulled low at cycle 15 of an operation:
  - `busy`, `done` and `result` go to 0 asynchronously.
  - No `done` appears afterwards.
  - A new DIVU 9 / 3 after reset returns 3.
